// File: rtl/ssr_pkg.sv
// Shared types and helpers for the SSR round-robin arbiter.
package ssr_pkg;

  typedef enum logic {
    SSR_IDLE  = 1'b0,
    SSR_GRANT = 1'b1
  } ssr_arb_state_t;

  // Index width for n request lines, never narrower than one bit.
  function automatic int ssr_idx_w(input int n);
    if (n <= 1) return 1;
    else        return $clog2(n);
  endfunction

endpackage

// File: rtl/ssr_rr_pick.sv
// Combinational rotate-priority picker: first eligible line at or above ptr,
// wrapping from NUM_REQ-1 back to 0. Lines set in mask are not eligible.
module ssr_rr_pick
  import ssr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = ssr_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] eff;
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     off;
  logic [IDX_W:0]     sum;

  assign eff = req & ~mask;
  // Rotate so that bit 0 of rot corresponds to line ptr.
  assign rot = NUM_REQ'({eff, eff} >> ptr);

  // Lowest set bit of the rotated vector, mapped back to an absolute index.
  always_comb begin
    any = 1'b0;
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any = 1'b1;
        off = (IDX_W+1)'(i);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
    idx = sum[IDX_W-1:0];
    for (int k = 0; k < NUM_REQ; k++) begin
      onehot[k] = any && (idx == IDX_W'(k));
    end
  end

endmodule

// File: rtl/ssr_rr_arbiter.sv
// Registered round-robin arbiter over NUM_REQ SSR request lines with a
// MAX_HOLD starvation guard. Unserved requests are forwarded on ssr_bits_out.
//
//  state     | meaning
//  ----------+-------------------------------------------------
//  SSR_IDLE  | no grant outstanding, waiting for any request
//  SSR_GRANT | one line granted, hold_cnt tracks its tenure
module ssr_rr_arbiter
  import ssr_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDX_W    = ssr_idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] ssr_bits_in,
  output logic [NUM_REQ-1:0] ssr_grant_out,
  output logic               ssr_grant_vld,
  output logic [IDX_W-1:0]   ssr_grant_idx,
  output logic [NUM_REQ-1:0] ssr_bits_out
);

  localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_MAX  = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HC_W'(MAX_HOLD - 1);

  ssr_arb_state_t     state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               vld_q, vld_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               cur_held;
  logic               hold_done;
  logic               take_new;

  // The current holder is always masked, so pick_any means "someone else waits".
  ssr_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (ssr_bits_in),
    .mask   (grant_q),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign cur_held  = |(ssr_bits_in & grant_q);
  // >= so that a saturated counter still lets a late arrival preempt.
  assign hold_done = (MAX_HOLD != 0) && (hold_cnt_q >= HOLD_LAST);

  // Next-state, grant and counter update.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    vld_d      = vld_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    take_new   = 1'b0;

    case (state_q)
      SSR_IDLE: begin
        if (pick_any) take_new = 1'b1;
      end
      SSR_GRANT: begin
        if (!cur_held) begin
          if (pick_any) begin
            take_new = 1'b1;
          end else begin
            state_d    = SSR_IDLE;
            grant_d    = '0;
            vld_d      = 1'b0;
            hold_cnt_d = '0;
          end
        end else if (hold_done && pick_any) begin
          take_new = 1'b1;
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SSR_IDLE;
        grant_d = '0;
        vld_d   = 1'b0;
      end
    endcase

    if (take_new) begin
      state_d    = SSR_GRANT;
      grant_d    = pick_onehot;
      vld_d      = 1'b1;
      idx_d      = pick_idx;
      rr_ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      hold_cnt_d = '0;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SSR_IDLE;
      grant_q    <= '0;
      vld_q      <= 1'b0;
      idx_q      <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      vld_q      <= vld_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign ssr_grant_out = grant_q;
  assign ssr_grant_vld = vld_q;
  assign ssr_grant_idx = idx_q;
  assign ssr_bits_out  = ssr_bits_in & ~grant_q;

endmodule

// File: tb/tb_ssr_rr_arbiter.sv
// Directed-vector scoreboard bench for ssr_rr_arbiter: main build (4 lines,
// MAX_HOLD=8) plus MAX_HOLD=0 and NUM_REQ=1 corner builds.
module tb_ssr_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] req_m = '0, req_nh = '0;
  logic [0:0] req_1 = '0;

  logic [3:0] g_m, b_m, g_nh, b_nh;
  logic [1:0] i_m, i_nh;
  logic       v_m, v_nh;
  logic [0:0] g_1, b_1, i_1;
  logic       v_1;

  ssr_rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .ssr_bits_in(req_m),
    .ssr_grant_out(g_m), .ssr_grant_vld(v_m), .ssr_grant_idx(i_m), .ssr_bits_out(b_m));

  ssr_rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(0)) dut_nh (
    .clk(clk), .rst_n(rst_n), .ssr_bits_in(req_nh),
    .ssr_grant_out(g_nh), .ssr_grant_vld(v_nh), .ssr_grant_idx(i_nh), .ssr_bits_out(b_nh));

  ssr_rr_arbiter #(.NUM_REQ(1), .MAX_HOLD(8)) dut_1 (
    .clk(clk), .rst_n(rst_n), .ssr_bits_in(req_1),
    .ssr_grant_out(g_1), .ssr_grant_vld(v_1), .ssr_grant_idx(i_1), .ssr_bits_out(b_1));

  typedef struct packed {
    logic [3:0] g;
    logic       v;
    logic [1:0] idx;
    logic [3:0] bits;
  } exp4_t;

  typedef struct packed {
    logic g;
    logic v;
    logic bits;
  } exp1_t;

  exp4_t q_m[$];
  exp4_t q_nh[$];
  exp1_t q_1[$];

  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0] last_m = '0, last_nh = '0;

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_m(input logic [3:0] r, input logic [3:0] g, input int n);
    repeat (n) begin
      @(negedge clk);
      req_m = r;
      if (|g) last_m = oh2idx(g);
      q_m.push_back('{g, |g, last_m, r & ~g});
    end
  endtask

  task automatic drive_nh(input logic [3:0] r, input logic [3:0] g, input int n);
    repeat (n) begin
      @(negedge clk);
      req_nh = r;
      if (|g) last_nh = oh2idx(g);
      q_nh.push_back('{g, |g, last_nh, r & ~g});
    end
  endtask

  task automatic drive_1(input logic r, input logic g, input int n);
    repeat (n) begin
      @(negedge clk);
      req_1 = r;
      q_1.push_back('{g, g, r & ~g});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    req_m   = '0;
    req_nh  = '0;
    req_1   = '0;
    last_m  = '0;
    last_nh = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expected entry per clock edge, compared 1 time unit after it.
  initial begin
    exp4_t e4;
    exp1_t e1;
    forever begin
      @(posedge clk);
      #1;
      if (q_m.size() > 0) begin
        e4 = q_m.pop_front();
        check("m_grant", 32'(g_m), 32'(e4.g));
        check("m_vld",   32'(v_m), 32'(e4.v));
        check("m_idx",   32'(i_m), 32'(e4.idx));
        check("m_bits",  32'(b_m), 32'(e4.bits));
      end
      if (q_nh.size() > 0) begin
        e4 = q_nh.pop_front();
        check("nh_grant", 32'(g_nh), 32'(e4.g));
        check("nh_vld",   32'(v_nh), 32'(e4.v));
        check("nh_idx",   32'(i_nh), 32'(e4.idx));
        check("nh_bits",  32'(b_nh), 32'(e4.bits));
      end
      if (q_1.size() > 0) begin
        e1 = q_1.pop_front();
        check("one_grant", 32'(g_1), 32'(e1.g));
        check("one_vld",   32'(v_1), 32'(e1.v));
        check("one_idx",   32'(i_1), 32'd0);
        check("one_bits",  32'(b_1), 32'(e1.bits));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-grant clears outputs without a clock edge.
    drive_m(4'b0000, 4'b0000, 2);
    drive_m(4'b0001, 4'b0001, 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_grant", 32'(g_m), 32'd0);
    check("rst_vld",   32'(v_m), 32'd0);
    check("rst_idx",   32'(i_m), 32'd0);
    check("rst_ptr",   32'(dut.rr_ptr_q), 32'd0);
    check("rst_bits",  32'(b_m), 32'b0001);
    req_m = '0;
    last_m = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First request after release, then wrap from rr_ptr=3 and forwarding.
    drive_m(4'b0100, 4'b0100, 1);
    drive_m(4'b1001, 4'b1000, 2);
    drive_m(4'b0001, 4'b0001, 1);
    drive_m(4'b0000, 4'b0000, 1);

    // Rotation: every granted line drops after two grant cycles.
    do_reset();
    drive_m(4'b1111, 4'b0001, 2);
    drive_m(4'b1110, 4'b0010, 1);
    drive_m(4'b1111, 4'b0010, 1);
    drive_m(4'b1101, 4'b0100, 1);
    drive_m(4'b1111, 4'b0100, 1);
    drive_m(4'b1011, 4'b1000, 1);
    drive_m(4'b1111, 4'b1000, 1);
    drive_m(4'b0111, 4'b0001, 1);
    drive_m(4'b1111, 4'b0001, 1);
    drive_m(4'b0000, 4'b0000, 1);

    // Preemption after 8 grant cycles, in both directions.
    drive_m(4'b0001, 4'b0001, 1);
    drive_m(4'b0101, 4'b0001, 7);
    drive_m(4'b0101, 4'b0100, 8);
    drive_m(4'b0101, 4'b0001, 1);
    drive_m(4'b0000, 4'b0000, 1);

    // Lone holder keeps the grant; counter saturates; late arrival preempts.
    drive_m(4'b0010, 4'b0010, 20);
    @(posedge clk);
    #2;
    check("hold_sat", 32'(dut.hold_cnt_q), 32'd8);
    drive_m(4'b1010, 4'b1000, 1);
    drive_m(4'b0000, 4'b0000, 1);

    // MAX_HOLD=0: never preempts.
    do_reset();
    drive_nh(4'b0101, 4'b0001, 20);
    drive_nh(4'b0100, 4'b0100, 1);
    drive_nh(4'b0000, 4'b0000, 1);

    // NUM_REQ=1: grant follows request by one cycle.
    drive_1(1'b0, 1'b0, 2);
    drive_1(1'b1, 1'b1, 12);
    drive_1(1'b0, 1'b0, 1);
    drive_1(1'b1, 1'b1, 1);
    drive_1(1'b0, 1'b0, 2);

    repeat (3) @(negedge clk);
    check("queues_drained", 32'(q_m.size() + q_nh.size() + q_1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
